// File: rtl/alu_rs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_rs_pkg: shared types for the ALU reservation station             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package alu_rs_pkg;

  localparam int ROB_ID_W = 32;
  localparam int DATA_W   = 32;
  localparam int TYPE_W   = 5;

  // Encoding shared with the decoder and the ALU.
  typedef enum logic [TYPE_W-1:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_AND   = 5'd2,
    ALU_OR    = 5'd3,
    ALU_XOR   = 5'd4,
    ALU_SLL   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_SRA   = 5'd7,
    ALU_SLT   = 5'd8,
    ALU_SLTU  = 5'd9,
    ALU_LUI   = 5'd10,
    ALU_AUIPC = 5'd11
  } alu_type_e;

  typedef struct packed {
    logic                busy;
    logic [TYPE_W-1:0]   op_type;
    logic [ROB_ID_W-1:0] rob_id;
    logic [DATA_W-1:0]   vj;
    logic [DATA_W-1:0]   vk;
    logic                qj_valid;
    logic [ROB_ID_W-1:0] qj;
    logic                qk_valid;
    logic [ROB_ID_W-1:0] qk;
    logic [DATA_W-1:0]   imm;
  } rs_entry_t;

  typedef struct packed {
    logic                valid;
    logic [ROB_ID_W-1:0] rob_id;
    logic [DATA_W-1:0]   value;
  } cdb_t;

  // Returns {q_valid, value} after snooping both buses; cdb0 wins a tag tie.
  function automatic logic [DATA_W:0] cdb_snoop(
    input logic                q_valid,
    input logic [ROB_ID_W-1:0] q,
    input logic [DATA_W-1:0]   v,
    input cdb_t                c0,
    input cdb_t                c1
  );
    if (q_valid && c0.valid && (c0.rob_id == q)) return {1'b0, c0.value};
    if (q_valid && c1.valid && (c1.rob_id == q)) return {1'b0, c1.value};
    return {q_valid, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_rs_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_rs_if: issue, CDB snoop and ALU dispatch bundle                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface alu_rs_if;
  import alu_rs_pkg::*;

  logic                issue_valid;
  logic                issue_ready;
  logic [TYPE_W-1:0]   issue_type;
  logic [ROB_ID_W-1:0] issue_rob_id;
  logic [DATA_W-1:0]   issue_vj;
  logic [DATA_W-1:0]   issue_vk;
  logic                issue_qj_valid;
  logic                issue_qk_valid;
  logic [ROB_ID_W-1:0] issue_qj;
  logic [ROB_ID_W-1:0] issue_qk;
  logic [DATA_W-1:0]   issue_imm;

  logic                cdb0_valid;
  logic [ROB_ID_W-1:0] cdb0_rob_id;
  logic [DATA_W-1:0]   cdb0_value;
  logic                cdb1_valid;
  logic [ROB_ID_W-1:0] cdb1_rob_id;
  logic [DATA_W-1:0]   cdb1_value;

  logic                alu_en;
  logic [ROB_ID_W-1:0] alu_rob_id;
  logic [DATA_W-1:0]   alu_data_j;
  logic [DATA_W-1:0]   alu_data_k;
  logic [DATA_W-1:0]   alu_imm;
  logic [TYPE_W-1:0]   alu_type;

  modport master (
    output issue_valid, issue_type, issue_rob_id, issue_vj, issue_vk,
           issue_qj_valid, issue_qk_valid, issue_qj, issue_qk, issue_imm,
           cdb0_valid, cdb0_rob_id, cdb0_value,
           cdb1_valid, cdb1_rob_id, cdb1_value,
    input  issue_ready, alu_en, alu_rob_id, alu_data_j, alu_data_k,
           alu_imm, alu_type
  );

  modport slave (
    input  issue_valid, issue_type, issue_rob_id, issue_vj, issue_vk,
           issue_qj_valid, issue_qk_valid, issue_qj, issue_qk, issue_imm,
           cdb0_valid, cdb0_rob_id, cdb0_value,
           cdb1_valid, cdb1_rob_id, cdb1_value,
    output issue_ready, alu_en, alu_rob_id, alu_data_j, alu_data_k,
           alu_imm, alu_type
  );

endinterface
`default_nettype wire

// File: rtl/alu_rs_lowest_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rs_lowest_pick: lowest-set-bit finder with found flag                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rs_lowest_pick #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_rs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_rs: ALU reservation station, CDB wakeup, lowest-index dispatch   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE = 8
) (
  input  logic     clk_in,
  input  logic     rst_in,
  input  logic     rdy_in,
  input  logic     flush,
  alu_rs_if.slave  bus
);

  localparam int c_idx_w = $clog2(RS_SIZE);

  rs_entry_t           r_entries [RS_SIZE];
  logic                r_alu_en;
  logic [ROB_ID_W-1:0] r_alu_rob_id;
  logic [DATA_W-1:0]   r_alu_data_j;
  logic [DATA_W-1:0]   r_alu_data_k;
  logic [DATA_W-1:0]   r_alu_imm;
  logic [TYPE_W-1:0]   r_alu_type;

  logic [RS_SIZE-1:0]  w_free;
  logic [RS_SIZE-1:0]  w_ready;
  logic                w_free_found;
  logic [c_idx_w-1:0]  w_free_idx;
  logic                w_sel_found;
  logic [c_idx_w-1:0]  w_sel_idx;
  logic                w_issue_fire;
  cdb_t                w_cdb0;
  cdb_t                w_cdb1;
  rs_entry_t           w_new;

  assign w_cdb0 = {bus.cdb0_valid, bus.cdb0_rob_id, bus.cdb0_value};
  assign w_cdb1 = {bus.cdb1_valid, bus.cdb1_rob_id, bus.cdb1_value};

  for (genvar g = 0; g < RS_SIZE; g++) begin : g_status
    assign w_free[g]  = ~r_entries[g].busy;
    assign w_ready[g] = r_entries[g].busy & ~r_entries[g].qj_valid & ~r_entries[g].qk_valid;
  end

  rs_lowest_pick #(.N(RS_SIZE)) u_free_pick (
    .i_req   (w_free),
    .o_found (w_free_found),
    .o_idx   (w_free_idx)
  );

  rs_lowest_pick #(.N(RS_SIZE)) u_ready_pick (
    .i_req   (w_ready),
    .o_found (w_sel_found),
    .o_idx   (w_sel_idx)
  );

  assign bus.issue_ready = w_free_found;
  assign w_issue_fire    = bus.issue_valid & w_free_found;

  always_comb begin
    w_new          = '0;
    w_new.busy     = 1'b1;
    w_new.op_type  = bus.issue_type;
    w_new.rob_id   = bus.issue_rob_id;
    w_new.qj       = bus.issue_qj;
    w_new.qk       = bus.issue_qk;
    w_new.imm      = bus.issue_imm;
    {w_new.qj_valid, w_new.vj} = cdb_snoop(bus.issue_qj_valid, bus.issue_qj, bus.issue_vj, w_cdb0, w_cdb1);
    {w_new.qk_valid, w_new.vk} = cdb_snoop(bus.issue_qk_valid, bus.issue_qk, bus.issue_vk, w_cdb0, w_cdb1);
  end

  // The free slot is never busy and the selected slot is never pending, so
  // issue, wakeup and dispatch always touch disjoint fields.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) r_entries[i] <= '0;
      r_alu_en     <= 1'b0;
      r_alu_rob_id <= '0;
      r_alu_data_j <= '0;
      r_alu_data_k <= '0;
      r_alu_imm    <= '0;
      r_alu_type   <= '0;
    end else if (flush) begin
      for (int i = 0; i < RS_SIZE; i++) r_entries[i].busy <= 1'b0;
      r_alu_en <= 1'b0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_entries[i].busy) begin
          {r_entries[i].qj_valid, r_entries[i].vj} <=
            cdb_snoop(r_entries[i].qj_valid, r_entries[i].qj, r_entries[i].vj, w_cdb0, w_cdb1);
          {r_entries[i].qk_valid, r_entries[i].vk} <=
            cdb_snoop(r_entries[i].qk_valid, r_entries[i].qk, r_entries[i].vk, w_cdb0, w_cdb1);
        end
      end
      if (w_issue_fire) r_entries[w_free_idx] <= w_new;
      if (w_sel_found) begin
        r_entries[w_sel_idx].busy <= 1'b0;
        r_alu_en     <= 1'b1;
        r_alu_rob_id <= r_entries[w_sel_idx].rob_id;
        r_alu_data_j <= r_entries[w_sel_idx].vj;
        r_alu_data_k <= r_entries[w_sel_idx].vk;
        r_alu_imm    <= r_entries[w_sel_idx].imm;
        r_alu_type   <= r_entries[w_sel_idx].op_type;
      end else begin
        r_alu_en <= 1'b0;
      end
    end
  end

  assign bus.alu_en     = r_alu_en;
  assign bus.alu_rob_id = r_alu_rob_id;
  assign bus.alu_data_j = r_alu_data_j;
  assign bus.alu_data_k = r_alu_data_k;
  assign bus.alu_imm    = r_alu_imm;
  assign bus.alu_type   = r_alu_type;

endmodule
`default_nettype wire

// File: tb/tb_alu_rs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_rs: directed vectors plus random run against a queue model    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int RS = 8;

  logic clk_in = 1'b0;
  logic rst_in, rdy_in, flush;

  alu_rs_if bus ();

  alu_rs #(.RS_SIZE(RS)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  typedef struct {
    logic        iv;
    logic [4:0]  t;
    logic [31:0] rob, vj, vk, imm, qj, qk;
    logic        qjv, qkv;
    logic        c0v, c1v;
    logic [31:0] c0id, c0val, c1id, c1val;
    logic        fl, rdy;
  } in_t;

  function automatic in_t idle_in();
    in_t x;
    x = '{iv: 0, t: 0, rob: 0, vj: 0, vk: 0, imm: 0, qj: 0, qk: 0, qjv: 0, qkv: 0,
          c0v: 0, c1v: 0, c0id: 0, c0val: 0, c1id: 0, c1val: 0, fl: 0, rdy: 1};
    return x;
  endfunction

  function automatic in_t iss(input logic [4:0] t, input logic [31:0] rob, input logic [31:0] vj,
                              input logic [31:0] vk, input logic [31:0] imm,
                              input logic qjv, input logic [31:0] qj,
                              input logic qkv, input logic [31:0] qk);
    in_t x;
    x = idle_in();
    x.iv = 1; x.t = t; x.rob = rob; x.vj = vj; x.vk = vk; x.imm = imm;
    x.qjv = qjv; x.qj = qj; x.qkv = qkv; x.qk = qk;
    return x;
  endfunction

  task automatic apply(input in_t x);
    bus.issue_valid    = x.iv;
    bus.issue_type     = x.t;
    bus.issue_rob_id   = x.rob;
    bus.issue_vj       = x.vj;
    bus.issue_vk       = x.vk;
    bus.issue_imm      = x.imm;
    bus.issue_qj_valid = x.qjv;
    bus.issue_qj       = x.qj;
    bus.issue_qk_valid = x.qkv;
    bus.issue_qk       = x.qk;
    bus.cdb0_valid     = x.c0v;
    bus.cdb0_rob_id    = x.c0id;
    bus.cdb0_value     = x.c0val;
    bus.cdb1_valid     = x.c1v;
    bus.cdb1_rob_id    = x.c1id;
    bus.cdb1_value     = x.c1val;
    flush              = x.fl;
    rdy_in             = x.rdy;
  endtask

  task automatic check_disp(input string n, input logic [31:0] rob, input logic [31:0] j,
                            input logic [31:0] k, input logic [31:0] imm, input logic [4:0] t);
    check({n, ".en"}, 32'(bus.alu_en), 1);
    check({n, ".rob"}, bus.alu_rob_id, rob);
    check({n, ".j"}, bus.alu_data_j, j);
    check({n, ".k"}, bus.alu_data_k, k);
    check({n, ".imm"}, bus.alu_imm, imm);
    check({n, ".type"}, 32'(bus.alu_type), 32'(t));
  endtask

  // Behavioural model: slots scanned in index order, operands resolved by tag.
  typedef struct {
    bit          busy;
    logic [4:0]  t;
    logic [31:0] rob, vj, vk, imm, qj, qk;
    bit          qjv, qkv;
  } m_ent_t;

  m_ent_t      m [RS];
  logic        m_en;
  logic [31:0] m_rob, m_j, m_k, m_imm;
  logic [4:0]  m_t;

  task automatic model_reset();
    for (int i = 0; i < RS; i++) m[i] = '{busy: 0, t: 0, rob: 0, vj: 0, vk: 0, imm: 0, qj: 0, qk: 0, qjv: 0, qkv: 0};
    m_en = 0; m_rob = 0; m_j = 0; m_k = 0; m_imm = 0; m_t = 0;
  endtask

  task automatic resolve(inout bit qv, inout logic [31:0] v, input logic [31:0] q, input in_t x);
    if (!qv) return;
    if (x.c0v && x.c0id == q) begin qv = 0; v = x.c0val; end
    else if (x.c1v && x.c1id == q) begin qv = 0; v = x.c1val; end
  endtask

  function automatic bit model_has_free();
    for (int i = 0; i < RS; i++) if (!m[i].busy) return 1;
    return 0;
  endfunction

  task automatic model_step(input in_t x);
    int sel, fr;
    m_ent_t e;
    if (x.fl) begin
      for (int i = 0; i < RS; i++) m[i].busy = 0;
      m_en = 0;
      return;
    end
    if (!x.rdy) return;
    sel = -1; fr = -1;
    for (int i = 0; i < RS; i++) begin
      if (sel < 0 && m[i].busy && !m[i].qjv && !m[i].qkv) sel = i;
      if (fr < 0 && !m[i].busy) fr = i;
    end
    if (sel >= 0) begin
      m_en = 1; m_rob = m[sel].rob; m_j = m[sel].vj; m_k = m[sel].vk;
      m_imm = m[sel].imm; m_t = m[sel].t; m[sel].busy = 0;
    end else m_en = 0;
    for (int i = 0; i < RS; i++) begin
      if (m[i].busy) begin
        resolve(m[i].qjv, m[i].vj, m[i].qj, x);
        resolve(m[i].qkv, m[i].vk, m[i].qk, x);
      end
    end
    if (x.iv && fr >= 0) begin
      e = '{busy: 1, t: x.t, rob: x.rob, vj: x.vj, vk: x.vk, imm: x.imm,
            qj: x.qj, qk: x.qk, qjv: x.qjv, qkv: x.qkv};
      resolve(e.qjv, e.vj, e.qj, x);
      resolve(e.qkv, e.vk, e.qk, x);
      m[fr] = e;
    end
  endtask

  typedef struct {
    in_t         x;
    logic [31:0] exp_j, exp_k;
  } vec_t;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vt [5];
    in_t  x;

    // Reset and idle
    apply(idle_in());
    rst_in = 1;
    tick(); tick();
    rst_in = 0;
    check("rst.en", 32'(bus.alu_en), 0);
    check("rst.rob", bus.alu_rob_id, 0);
    check("rst.j", bus.alu_data_j, 0);
    check("rst.k", bus.alu_data_k, 0);
    check("rst.imm", bus.alu_imm, 0);
    check("rst.type", 32'(bus.alu_type), 0);
    check("rst.ready", 32'(bus.issue_ready), 1);
    tick();
    check("idle.en", 32'(bus.alu_en), 0);

    // Single-issue vectors, including issue-time bypass and cdb0 tie priority
    vt[0].x = iss(ALU_ADD, 3, 5, 7, 0, 0, 0, 0, 0);
    vt[0].exp_j = 5; vt[0].exp_k = 7;
    vt[1].x = iss(ALU_SUB, 32'h1f, 32'hffff_ffff, 32'h8000_0000, 32'h123, 0, 0, 0, 0);
    vt[1].exp_j = 32'hffff_ffff; vt[1].exp_k = 32'h8000_0000;
    vt[2].x = iss(ALU_XOR, 4, 32'hdead, 32'h22, 32'h4, 1, 2, 0, 0);
    vt[2].x.c1v = 1; vt[2].x.c1id = 2; vt[2].x.c1val = 32'h10;
    vt[2].exp_j = 32'h10; vt[2].exp_k = 32'h22;
    vt[3].x = iss(ALU_AND, 6, 0, 0, 32'h66, 1, 5, 1, 5);
    vt[3].x.c0v = 1; vt[3].x.c0id = 5; vt[3].x.c0val = 32'haaaa;
    vt[3].x.c1v = 1; vt[3].x.c1id = 5; vt[3].x.c1val = 32'hbbbb;
    vt[3].exp_j = 32'haaaa; vt[3].exp_k = 32'haaaa;
    vt[4].x = iss(ALU_OR, 7, 0, 0, 32'h77, 1, 8, 1, 9);
    vt[4].x.c0v = 1; vt[4].x.c0id = 9; vt[4].x.c0val = 32'h99;
    vt[4].x.c1v = 1; vt[4].x.c1id = 8; vt[4].x.c1val = 32'h88;
    vt[4].exp_j = 32'h88; vt[4].exp_k = 32'h99;

    for (int v = 0; v < 5; v++) begin
      apply(vt[v].x);
      tick();
      check($sformatf("vec%0d.early", v), 32'(bus.alu_en), 0);
      apply(idle_in());
      tick();
      check_disp($sformatf("vec%0d", v), vt[v].x.rob, vt[v].exp_j, vt[v].exp_k, vt[v].x.imm, vt[v].x.t);
      tick();
      check($sformatf("vec%0d.after", v), 32'(bus.alu_en), 0);
    end

    // Wakeup through cdb1, with an unrelated cdb0 tag beforehand
    apply(iss(ALU_ADD, 4, 0, 3, 0, 1, 2, 0, 0));
    tick();
    x = idle_in(); x.c0v = 1; x.c0id = 7; x.c0val = 32'hbad;
    apply(x);
    tick();
    apply(idle_in());
    tick();
    check("wake.nomatch", 32'(bus.alu_en), 0);
    x = idle_in(); x.c1v = 1; x.c1id = 2; x.c1val = 32'h10;
    apply(x);
    tick();
    check("wake.t1", 32'(bus.alu_en), 0);
    apply(idle_in());
    tick();
    check_disp("wake", 4, 32'h10, 3, 0, ALU_ADD);

    // Fill all entries pending on rob 9, then release them in order
    for (int k = 0; k < RS; k++) begin
      if (k == RS - 1) check("full.pre_ready", 32'(bus.issue_ready), 1);
      apply(iss(ALU_SLL, 10 + k, 0, 32'h100 + k, k, 1, 9, 0, 0));
      tick();
    end
    check("full.ready", 32'(bus.issue_ready), 0);
    apply(iss(ALU_ADD, 99, 1, 1, 0, 0, 0, 0, 0));
    tick();
    check("full.ignored_ready", 32'(bus.issue_ready), 0);
    apply(idle_in());
    tick();
    tick();
    check("full.ignored_en", 32'(bus.alu_en), 0);
    x = idle_in(); x.c0v = 1; x.c0id = 9; x.c0val = 32'h55;
    apply(x);
    tick();
    check("full.wake_en", 32'(bus.alu_en), 0);
    check("full.wake_ready", 32'(bus.issue_ready), 0);
    apply(idle_in());
    for (int k = 0; k < RS; k++) begin
      tick();
      check_disp($sformatf("full.d%0d", k), 10 + k, 32'h55, 32'h100 + k, k, ALU_SLL);
      if (k == 0) check("full.ready_back", 32'(bus.issue_ready), 1);
    end
    tick();
    check("full.drained", 32'(bus.alu_en), 0);

    // Flush with a simultaneous issue
    for (int k = 0; k < 3; k++) begin
      apply(iss(ALU_SRA, 30 + k, 0, 0, 0, 1, 20, 0, 0));
      tick();
    end
    x = iss(ALU_ADD, 40, 1, 2, 3, 0, 0, 0, 0);
    x.fl = 1;
    apply(x);
    tick();
    check("flush.en", 32'(bus.alu_en), 0);
    check("flush.ready", 32'(bus.issue_ready), 1);
    x = idle_in(); x.c0v = 1; x.c0id = 20; x.c0val = 1;
    apply(x);
    tick();
    apply(idle_in());
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("flush.quiet%0d", k), 32'(bus.alu_en), 0);
    end

    // Stall while a dispatch is showing and another entry is ready
    apply(iss(ALU_SLT, 50, 1, 2, 3, 0, 0, 0, 0));
    tick();
    apply(iss(ALU_SLTU, 51, 4, 5, 6, 0, 0, 0, 0));
    tick();
    check_disp("stall.first", 50, 1, 2, 3, ALU_SLT);
    x = idle_in(); x.rdy = 0;
    apply(x);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall.en%0d", k), 32'(bus.alu_en), 1);
      check($sformatf("stall.rob%0d", k), bus.alu_rob_id, 50);
    end
    apply(idle_in());
    tick();
    check_disp("stall.resume", 51, 4, 5, 6, ALU_SLTU);
    tick();
    check("stall.after", 32'(bus.alu_en), 0);

    // Randomized run against the model
    rst_in = 1;
    tick(); tick();
    rst_in = 0;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      check("rnd.en", 32'(bus.alu_en), 32'(m_en));
      check("rnd.rob", bus.alu_rob_id, m_rob);
      check("rnd.j", bus.alu_data_j, m_j);
      check("rnd.k", bus.alu_data_k, m_k);
      check("rnd.imm", bus.alu_imm, m_imm);
      check("rnd.type", 32'(bus.alu_type), 32'(m_t));
      check("rnd.ready", 32'(bus.issue_ready), 32'(model_has_free()));
      x = idle_in();
      x.rdy   = ($urandom % 8) != 0;
      x.fl    = ($urandom % 50) == 0;
      x.iv    = ($urandom % 4) != 0;
      x.t     = 5'($urandom_range(11, 0));
      x.rob   = $urandom;
      x.vj    = $urandom;
      x.vk    = $urandom;
      x.imm   = $urandom;
      x.qjv   = ($urandom % 2) == 0;
      x.qkv   = ($urandom % 3) == 0;
      x.qj    = $urandom_range(4, 1);
      x.qk    = $urandom_range(4, 1);
      x.c0v   = x.rdy && (($urandom % 3) == 0);
      x.c0id  = $urandom_range(4, 1);
      x.c0val = $urandom;
      x.c1v   = x.rdy && (($urandom % 3) == 0);
      x.c1id  = $urandom_range(4, 1);
      x.c1val = $urandom;
      apply(x);
      model_step(x);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_rs.md
# alu_rs

Reservation station for integer ALU instructions in the out-of-order core. It buffers issued ALU instructions until both source operands are available, snooping two common-data-bus (CDB) broadcasts for the operands. Each cycle it dispatches at most one ready instruction, with registered outputs, to the single-cycle ALU directly downstream.

## Interface
Parameters:
- `RS_SIZE`, 8: number of entries; power of two, at least 2.

Ports:
- `clk_in` in 1: clock; the only clock.
- `rst_in` in 1: reset, synchronous, active-high.
- `rdy_in` in 1: global enable; when low, all state holds.
- `flush` in 1: mispredict flush; discards all entries.
- `issue_valid` in 1: issue request this cycle.
- `issue_ready` out 1: at least one entry is free (combinational from registered busy bits).
- `issue_type` in 5: operation type, same encoding the ALU consumes.
- `issue_rob_id` in 32: destination ROB id.
- `issue_vj`, `issue_vk` in 32: operand values, meaningful when the matching q-valid is 0.
- `issue_qj_valid`, `issue_qk_valid` in 1: 1 means the operand is still pending.
- `issue_qj`, `issue_qk` in 32: ROB id that produces each pending operand.
- `issue_imm` in 32: immediate.
- `cdb0_valid` in 1, `cdb0_rob_id` in 32, `cdb0_value` in 32: ALU result broadcast.
- `cdb1_valid` in 1, `cdb1_rob_id` in 32, `cdb1_value` in 32: load/store result broadcast.
- `alu_en` out 1: dispatch valid (registered).
- `alu_rob_id`, `alu_data_j`, `alu_data_k`, `alu_imm` out 32: dispatched fields (registered).
- `alu_type` out 5: dispatched type (registered).

## Operation
- Each entry holds: `busy`, `type`, `rob_id`, `vj`, `vk`, `qj_valid`, `qj`, `qk_valid`, `qk`, `imm`.
- **Issue.** On an accepted issue (`issue_valid && issue_ready`), write the lowest-index free entry.
  - If `issue_valid` is high while `issue_ready` is low, the request is ignored; the producer must hold it.
- **Issue-time bypass.** If a pending issued operand's q matches a valid CDB tag in the same cycle, store the CDB value and clear the q-valid.
- **Wakeup.** For every busy entry with `qX_valid` set and `qX == cdbN_rob_id` while `cdbN_valid` is high: set `vX = cdbN_value` and clear `qX_valid`.
  - If both CDBs carry the same tag, cdb0 wins.
- **Select.** Ready means `busy && !qj_valid && !qk_valid`, evaluated on registered state. A ready entry is never also issued or woken in the same cycle.
  - Choose the lowest-index ready entry.
  - Latch its fields into the `alu_*` registers, set `alu_en = 1`, and clear its `busy` bit.
  - If no entry is ready, `alu_en = 0`; the other `alu_*` registers hold their values.
- **Flush.** Clear all `busy` bits and set `alu_en = 0` at the edge. The same-cycle issue is dropped.
- **Priority:** `rst_in` > `flush` > `!rdy_in` (hold everything, including `alu_en`) > normal operation.
- No arithmetic is performed in this block. Values pass through unmodified at 32 bits.

## Timing
- **Reset values:**
  - all `busy` = 0, `alu_en` = 0;
  - `alu_rob_id`, `alu_data_j`, `alu_data_k`, `alu_imm`, `alu_type` = 0;
  - `issue_ready` = 1.
- **Minimum latency:**
  - An instruction issued with both operands ready in cycle t has `alu_en = 1` in cycle t+2.
  - An operand woken by the CDB in cycle t allows `alu_en` in cycle t+2.
- **Entry reuse:** an entry dispatched at the end of cycle t is free from cycle t+1. `issue_ready` does not see a same-cycle free.
- **Throughput:** one dispatch per cycle, and one issue per cycle, concurrently.
- **Full:** all `RS_SIZE` entries busy gives `issue_ready` = 0.
- **Empty:** `alu_en` = 0 each cycle.
- **Stall:** with `rdy_in` low for N cycles, outputs and entries are frozen and CDB inputs are ignored. Producers must not broadcast while `rdy_in` is low.

## Structure
- **Shared package:**
  - 5-bit ALU type encodings, shared with the decoder and the ALU;
  - `ROB_ID_W` = 32;
  - a packed RS entry struct;
  - `CDB` port bundle struct.
- **Sub-module `rs_lowest_pick`:** a parameterised lowest-set-bit finder returning a found flag and an index. It is instantiated twice: once for the free-entry search and once for ready selection.

## Test plan
- **Reset/idle:** assert `rst_in` for 2 cycles, then issue nothing → `alu_en` = 0, all `alu_*` = 0, `issue_ready` = 1.
- **Ready issue:** issue in cycle 1 with type ADD, rob 3, vj = 5, vk = 7, both q-valid 0 → cycle 3: `alu_en` = 1, `alu_rob_id` = 3, `alu_data_j` = 5, `alu_data_k` = 7; cycle 4: `alu_en` = 0.
- **Wakeup:** issue rob 4 with qj = 2 pending; cdb1 broadcasts rob 2 with value 0x10 in cycle 5 → `alu_en` = 1 in cycle 7 with `alu_data_j` = 0x10. Repeat with the broadcast in the issue cycle itself (bypass) → same value, dispatch at issue cycle + 2.
- **Full and ordering:** issue 8 instructions, each pending on rob 9 → `issue_ready` = 0, and a 9th request is ignored. Broadcast rob 9 on cdb0 → dispatches in entry order 0..7 on consecutive cycles, and `issue_ready` returns to 1 the cycle after the first dispatch.
- **Flush:** fill 3 entries, then assert `flush` together with `issue_valid` → next cycle `alu_en` = 0, `issue_ready` = 1, and no dispatch ever follows.
- **Stall:** with one ready entry, hold `rdy_in` low for 3 cycles → no dispatch and outputs frozen; dispatch occurs 1 cycle after `rdy_in` rises.
